// File: rtl/fifo_flags_pkg.sv
// rtl/fifo_flags_pkg.sv - default lane FIFO sizing, lane count and flag helpers
// Shared by fifo_flags and fifo_mem.
package fifo_flags_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 2;
  localparam int NUM_LANES      = 5;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{full: 1'b0, almost_full: 1'b0,
                                            empty: 1'b1, almost_empty: 1'b1};

  function automatic fifo_status_t status_from_count(input int cnt, input int depth,
                                                     input int af, input int ae);
    fifo_status_t s;
    s.full         = (cnt == depth);
    s.almost_full  = (cnt >= af);
    s.empty        = (cnt == 0);
    s.almost_empty = (cnt <= ae);
    return s;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register file, sync write, registered read
// Storage is never reset; only the read register clears so data_out starts at zero.
module fifo_mem
  import fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A same-address write and read in one cycle returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - lane FIFO with registered full/almost_full/empty/almost_empty flags
// Optional sticky overflow/underflow outputs under FIFO_ERR_FLAGS_EN.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  fifo_status_t          status_q, status_d;
  logic                  valid_out_q, valid_out_d;
  logic                  pop_acc, push_acc;

  // Flags come from the next count so they line up with count every cycle.
  always_comb begin
    pop_acc     = enable & pop & ~status_q.empty;
    push_acc    = enable & push & (~status_q.full | pop_acc);
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(pop_acc);
    count_d     = count_q + (ADDR_WIDTH+1)'(push_acc) - (ADDR_WIDTH+1)'(pop_acc);
    valid_out_d = pop_acc;
    status_d    = status_from_count(int'(count_d), DEPTH, AF_THRESH, AE_THRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      status_q    <= STATUS_RESET;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      status_q    <= status_d;
      valid_out_q <= valid_out_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign valid_out    = valid_out_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign almost_full  = status_q.almost_full;
  assign empty        = status_q.empty;
  assign almost_empty = status_q.almost_empty;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (enable & push & ~push_acc);
    underflow_d = underflow_q | (enable & pop & status_q.empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb/tb_fifo_flags.sv - scoreboard bench for fifo_flags against a queue model
// Honours FIFO_ERR_FLAGS_EN when the DUT is built with it.
module tb_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic          almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
  logic          m_ovf;
  logic          m_unf;
`endif

  int            passed;
  int            total;
  logic          mon_en;
  logic          exp_valid;
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_data [$];

  fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic check_model_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, " count"}, int'(count), n);
    check({tag, " full"}, int'(full), int'(n == DEPTH));
    check({tag, " almost_full"}, int'(almost_full), int'(n >= AF));
    check({tag, " empty"}, int'(empty), int'(n == 0));
    check({tag, " almost_empty"}, int'(almost_empty), int'(n <= AE));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, " overflow"}, int'(overflow), int'(m_ovf));
    check({tag, " underflow"}, int'(underflow), int'(m_unf));
`endif
  endtask

  // One clock of stimulus; the model advances to the state after the next edge.
  task automatic step(input logic en, input logic pu, input logic [DW-1:0] d, input logic po);
    int   n;
    logic pa;
    logic wa;
    @(negedge clk);
    enable  = en;
    push    = pu;
    data_in = d;
    pop     = po;
    n  = model_q.size();
    pa = en && po && (n > 0);
    wa = en && pu && ((n < DEPTH) || pa);
`ifdef FIFO_ERR_FLAGS_EN
    if (en && pu && !wa) m_ovf = 1'b1;
    if (en && po && (n == 0)) m_unf = 1'b1;
`endif
    if (pa) exp_data.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    exp_valid = pa;
  endtask

  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !reset) begin
        check_model_state("cycle");
        check("valid_out", int'(valid_out), int'(exp_valid));
        if (valid_out) begin
          if (exp_data.size() == 0) begin
            total++;
            $display("FAIL unexpected_valid: got data 0x%0h, expected no output at %0t", data_out, $time);
          end else begin
            e = exp_data.pop_front();
            check("data_out", int'(data_out), int'(e));
          end
        end
      end
    end
  end

  initial begin : driver
    passed    = 0;
    total     = 0;
    mon_en    = 1'b0;
    exp_valid = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = '0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_model_state("reset");
    check("reset valid_out", int'(valid_out), 0);
    check("reset data_out", int'(data_out), 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'(8'h11 + i), 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'(8'hA0 + i), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h66, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'(8'hD0 + i), 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_q.delete();
    exp_data.delete();
    exp_valid = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    check_model_state("midreset");
    check("midreset valid_out", int'(valid_out), 0);
    check("midreset data_out", int'(data_out), 0);
    @(negedge clk);
    enable = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    reset  = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic pu;
      logic po;
      if ((i / 50) % 2 == 0) begin
        pu = ($urandom_range(0, 3) != 0);
        po = ($urandom_range(0, 3) == 0);
      end else begin
        pu = ($urandom_range(0, 3) == 0);
        po = ($urandom_range(0, 3) != 0);
      end
      step(($urandom_range(0, 7) != 0), pu, DW'($urandom), po);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    check("drained scoreboard", exp_data.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
